prbs_error_detector: RTL
========================

Name: prbs_error_detector

Overview:
- Bit-level front end of the noise tester.
- Compares a received serial stream against a locally regenerated PRBS7 sequence (x^7 + x^6 + 1).
- Produces one error strobe per mismatched bit, plus a qualifying enable.
- Sits directly upstream of error_counter: err_out drives its in_1, err_valid drives its enable.

Parameters:
- LOCK_CNT, 16, consecutive matching bits required in VERIFY before LOCKED (2..255).
- LOS_WINDOW, 64, valid bits per loss-of-sync observation window in LOCKED (2..1023).
- LOS_THRESH, 8, errors within one window that force return to SEARCH (1..LOS_WINDOW).

Ports:
- clk, input, 1, system clock (50 MHz); all logic on rising edge.
- reset, input, 1, asynchronous active-high reset; clears all state immediately.
- rx_bit, input, 1, received data bit; sampled only when rx_valid=1.
- rx_valid, input, 1, rx_bit qualifier; one bit per cycle when high.
- err_out, output, 1, one-cycle error strobe to the downstream counter.
- err_valid, output, 1, high for each checked bit while LOCKED.
- locked, output, 1, high while the state is LOCKED.
- state, output, 2, 0=SEARCH, 1=VERIFY, 2=LOCKED (3 unused).

Behaviour:
- Reset values:
  - state=SEARCH; err_out=0, err_valid=0, locked=0.
  - Shift register sr[6:0]=0; fill count, good count, window count, error count all 0.
- sr ordering and prediction:
  - sr[0] holds the newest bit.
  - Predicted bit pred = sr[6] ^ sr[5].
  - Every shift is sr <= {sr[5:0], new_bit}.
- rx_valid=0: no state, sr, or counter change; err_out=0 and err_valid=0 next cycle.
- SEARCH:
  - Each valid bit shifts rx_bit into sr and increments the fill count.
  - On the 7th valid bit: clear the fill count and go to VERIFY.
- VERIFY:
  - Each valid bit shifts rx_bit into sr (self-synchronising).
  - rx_bit == pred: increment good count. rx_bit != pred: clear good count.
  - If sr after the shift is all zero, clear good count (blocks lock on an all-zero stream).
  - When good count reaches LOCK_CNT: go to LOCKED and clear window and error counts.
- LOCKED:
  - sr free-runs on pred; rx_bit is not shifted in.
  - Each valid bit: err = rx_bit ^ pred; window count increments; error count increments if err.
  - If error count reaches LOS_THRESH: go to SEARCH; clear sr, fill count, and good count.
  - If window count reaches LOS_WINDOW without hitting the threshold: clear window and error counts.
  - If threshold and window end fall on the same bit, threshold wins and the state goes to SEARCH.
- Outputs:
  - err_out and err_valid are registered, one cycle after the valid input.
  - err_valid = rx_valid & (state==LOCKED before the update).
  - err_out = err_valid & err.
  - The bit that triggers loss-of-sync still produces err_out=1 and err_valid=1.
  - locked is combinational from state.
- Counter widths:
  - Good count: 8 bits. Window count and error count: 10 bits.
  - No counter wraps; each saturates at its compare value.
- Reset mid-operation: asynchronous clear to reset values regardless of state; the next valid bit restarts SEARCH.

Optional Feature:
- ERR_INJECT_EN defined:
  - Adds input port inj_err (1 bit).
  - When inj_err=1 with rx_valid=1 in LOCKED, the computed err is inverted before it is registered and counted toward LOS_THRESH.
  - Used for self-test of the error path.
- ERR_INJECT_EN undefined: port absent, no inversion logic.

Test Plan:
- Reset: assert reset mid-cycle → all outputs 0 and state=0 before the next clk edge; release, then feed a clean PRBS7 stream with rx_valid=1 → state 0→1 after 7 bits, 1→2 after 16 more; locked=1 at bit 23; err_out stays 0; err_valid=1 from the following cycle.
- Single error: in LOCKED, flip one rx_bit → exactly one err_out=1 pulse one cycle later; state stays LOCKED; downstream error_counter count goes 0→1.
- Loss of sync: in LOCKED, invert 8 bits within one 64-bit window → 8 err_out pulses, then state=0, locked=0, err_valid=0; clean stream afterwards relocks after 23 bits.
- Below threshold: 7 errors in window 1, 7 in window 2 → 14 err_out pulses and locked stays 1 (window counts cleared at bit 64).
- Gaps and zeros: toggle rx_valid 1/0 every cycle on clean PRBS → lock after 23 valid bits (46 cycles) with no spurious pulses; all-zero stream → state never leaves VERIFY.
- With ERR_INJECT_EN: hold inj_err=1 for 3 valid bits in LOCKED → 3 err_out pulses; state stays LOCKED.

Source files
------------

// File: rtl/prbs_error_detector.sv
// PRBS7 (x^7 + x^6 + 1) receive checker: SEARCH -> VERIFY -> LOCKED, emitting per-bit error strobes.
// Optional macro ERR_INJECT_EN adds inj_err, which inverts the computed error in LOCKED for self-test.
module prbs_error_detector #(
  parameter int LOCK_CNT   = 16,
  parameter int LOS_WINDOW = 64,
  parameter int LOS_THRESH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_bit,
  input  logic       rx_valid,
`ifdef ERR_INJECT_EN
  input  logic       inj_err,
`endif
  output logic       err_out,
  output logic       err_valid,
  output logic       locked,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [7:0] LOCK_CNT_V   = 8'(LOCK_CNT);
  localparam logic [9:0] LOS_WINDOW_V = 10'(LOS_WINDOW);
  localparam logic [9:0] LOS_THRESH_V = 10'(LOS_THRESH);

  state_t      state_r;
  logic [6:0]  sr_r;
  logic [2:0]  fill_cnt_r;
  logic [7:0]  good_cnt_r;
  logic [9:0]  win_cnt_r;
  logic [9:0]  err_cnt_r;

  logic        pred_s;
  logic [6:0]  sr_shift_s;
  logic        err_s;
  logic [7:0]  good_next_s;
  logic [9:0]  win_next_s;
  logic [9:0]  err_next_s;

  // Prediction, error and saturating next-count values for the current bit.
  always_comb begin
    pred_s      = sr_r[6] ^ sr_r[5];
    sr_shift_s  = {sr_r[5:0], rx_bit};
`ifdef ERR_INJECT_EN
    err_s       = rx_bit ^ pred_s ^ inj_err;
`else
    err_s       = rx_bit ^ pred_s;
`endif
    // An all-zero register would trivially self-predict, so it never counts as good.
    good_next_s = ((rx_bit == pred_s) && (sr_shift_s != 7'd0))
                  ? ((good_cnt_r == LOCK_CNT_V) ? good_cnt_r : good_cnt_r + 8'd1)
                  : 8'd0;
    win_next_s  = (win_cnt_r == LOS_WINDOW_V) ? win_cnt_r : win_cnt_r + 10'd1;
    err_next_s  = (err_s && (err_cnt_r != LOS_THRESH_V)) ? err_cnt_r + 10'd1 : err_cnt_r;
  end

  // Sync state machine, shift register, counters and registered error outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= SEARCH;
      sr_r       <= 7'd0;
      fill_cnt_r <= 3'd0;
      good_cnt_r <= 8'd0;
      win_cnt_r  <= 10'd0;
      err_cnt_r  <= 10'd0;
      err_valid  <= 1'b0;
      err_out    <= 1'b0;
    end else begin
      err_valid <= rx_valid && (state_r == LOCKED);
      err_out   <= rx_valid && (state_r == LOCKED) && err_s;
      if (rx_valid) begin
        case (state_r)
          SEARCH: begin
            sr_r <= sr_shift_s;
            if (fill_cnt_r == 3'd6) begin
              fill_cnt_r <= 3'd0;
              state_r    <= VERIFY;
            end else begin
              fill_cnt_r <= fill_cnt_r + 3'd1;
            end
          end
          VERIFY: begin
            sr_r       <= sr_shift_s;
            good_cnt_r <= good_next_s;
            if (good_next_s == LOCK_CNT_V) begin
              state_r   <= LOCKED;
              win_cnt_r <= 10'd0;
              err_cnt_r <= 10'd0;
            end else begin
              state_r <= VERIFY;
            end
          end
          LOCKED: begin
            // Threshold is tested first so it wins over a coincident window end.
            if (err_next_s == LOS_THRESH_V) begin
              state_r    <= SEARCH;
              sr_r       <= 7'd0;
              fill_cnt_r <= 3'd0;
              good_cnt_r <= 8'd0;
              win_cnt_r  <= 10'd0;
              err_cnt_r  <= 10'd0;
            end else if (win_next_s == LOS_WINDOW_V) begin
              sr_r      <= {sr_r[5:0], pred_s};
              win_cnt_r <= 10'd0;
              err_cnt_r <= 10'd0;
            end else begin
              sr_r      <= {sr_r[5:0], pred_s};
              win_cnt_r <= win_next_s;
              err_cnt_r <= err_next_s;
            end
          end
          default: begin
            state_r    <= SEARCH;
            sr_r       <= 7'd0;
            fill_cnt_r <= 3'd0;
            good_cnt_r <= 8'd0;
          end
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

  assign locked = (state_r == LOCKED);
  assign state  = state_r;

endmodule
